instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Parameters
REQ-001 RESET_PC, 64'h0, PC loaded on reset.
REQ-002 HLT_WORD, 32'hD4400000, instruction word that halts fetch.

Interface
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  64  fetch address; equals pc.
REQ-007 imem_ack  input  1  memory response valid; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  instruction is presented to the decode/control stage.
REQ-010 instruction  output  32  held instruction word, stable while instr_valid=1.
REQ-011 instr_ready  input  1  decode/control stage accepts the instruction.
REQ-012 pc_out  output  64  address of the presented instruction.
REQ-013 branch  input  1  conditional branch (CBZ) asserted by control; sampled only on accept.
REQ-014 zero  input  1  ALU zero flag; sampled only on accept.
REQ-015 branch_uncond  input  1  unconditional branch (B); sampled only on accept.
REQ-016 branch_offset  input  64  sign-extended word offset; sampled only on accept.
REQ-017 halted  output  1  fetch has stopped on HLT_WORD.
REQ-018 instr_count  output  32  number of accepted instructions.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, HOLD and HALT.
REQ-020 IDLE SHALL last exactly one cycle after reset release and then go to FETCH.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL be pc, held stable until imem_ack.
REQ-022 An imem_ack in FETCH SHALL capture imem_rdata into instruction and move the FSM to HOLD; an ack in the same cycle as the first req cycle SHALL be accepted.
REQ-023 imem_ack outside FETCH SHALL be ignored with no state change.
REQ-024 instr_valid SHALL be 1 only in HOLD; instruction and pc_out SHALL be held while instr_ready=0.
REQ-025 Accept SHALL mean instr_valid=1 and instr_ready=1 in the same cycle.
REQ-026 On accept, the next pc SHALL be pc + (branch_offset << 2) when branch_uncond=1, or when branch=1 and zero=1.
REQ-027 Otherwise, on accept, the next pc SHALL be pc + 4.
REQ-028 branch_uncond SHALL take priority when it and branch are both set.
REQ-029 All PC arithmetic SHALL be modulo 2^64; wrap-around is silent, with no flag.
REQ-030 pc[1:0] SHALL always be 2'b00.
REQ-031 On accept of a non-HLT word, the FSM SHALL return to FETCH in the next cycle; throughput with a zero-wait memory SHALL be one instruction per 2 cycles.
REQ-032 On accept of a word equal to HLT_WORD, the FSM SHALL go to HALT, pc SHALL NOT advance, and halted SHALL become 1.
REQ-033 HALT SHALL be left only by reset; in HALT, imem_req=0 and instr_valid=0.
REQ-034 instr_count SHALL increment by 1 on each accept, including the HLT accept, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-035 Branch inputs SHALL have no effect in any cycle without an accept.
REQ-036 Latency from imem_ack to instr_valid SHALL be 1 cycle.

Reset
REQ-037 reset_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instruction=0, halted=0, instr_count=0.
REQ-038 Reset in the middle of an outstanding request SHALL abandon the request; a late imem_ack after reset is ignored per REQ-023.
REQ-039 Every output SHALL hold its reset value while reset_n=0.

Verification
REQ-040 Zero-wait memory, instr_ready=1 always, no branches -> imem_addr sequence 0, 4, 8, 12; instr_valid pulses every 2nd cycle; instr_count=4 after four accepts.
REQ-041 CBZ at pc=0x10 with branch=1, zero=1, offset=64'hFFFF_FFFF_FFFF_FFFE -> next fetch at 0x08; the same with zero=0 -> next fetch at 0x14.
REQ-042 instr_ready=0 for 5 cycles with word 0x8B020020 at pc 0x20 -> instruction and pc_out held constant, no new imem_req; pc=0x24 after accept.
REQ-043 Fetch of 32'hD4400000 at pc 0x30, accepted -> halted=1, imem_req stays 0 for 20 cycles, pc_out=0x30, instr_count incremented once.
REQ-044 pc=64'hFFFF_FFFF_FFFF_FFFC accepted without branch -> next imem_addr=0; B with offset 1 from the same pc -> 0.
REQ-045 reset_n pulled low mid-FETCH with imem_ack arriving 1 cycle after release -> ack ignored; outputs at reset values; first imem_req at RESET_PC 1 cycle after release.

Source files
------------

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch bus: instruction memory port, decode handshake and branch controls
interface instr_fetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        instr_ready;
  logic [63:0] pc_out;
  logic        branch;
  logic        zero;
  logic        branch_uncond;
  logic [63:0] branch_offset;
  logic        halted;
  logic [31:0] instr_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, pc_out, halted, instr_count,
    input  imem_ack, imem_rdata, instr_ready, branch, zero, branch_uncond, branch_offset
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, pc_out, halted, instr_count,
    output imem_ack, imem_rdata, instr_ready, branch, zero, branch_uncond, branch_offset
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-issue instruction fetch with hold handshake, CBZ/B redirect and HLT stop
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] HLT_WORD = 32'hD440_0000
) (
  input logic           clock,
  input logic           reset_n,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        fetch_done, accept, is_hlt, take_branch;

  assign fetch_done  = (state_q == FETCH) && bus.imem_ack;
  assign accept      = (state_q == HOLD) && bus.instr_ready;
  assign is_hlt      = (instr_q == HLT_WORD);
  assign take_branch = bus.branch_uncond || (bus.branch && bus.zero);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (bus.imem_ack) state_d = HOLD;
      HOLD:    if (bus.instr_ready) state_d = is_hlt ? HALT : FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state_q == FETCH);
    bus.instr_valid = (state_q == HOLD);
    bus.halted      = (state_q == HALT);
  end

  // Offset and +4 keep the low two bits clear, so pc stays word aligned without masking.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    if (fetch_done) instr_d = bus.imem_rdata;
    if (accept) begin
      count_d = count_q + 32'd1;
      if (!is_hlt) pc_d = take_branch ? pc_q + (bus.branch_offset << 2) : pc_q + 64'd4;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= {RESET_PC[63:2], 2'b00};
      instr_q <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc_out      = pc_q;
  assign bus.instruction = instr_q;
  assign bus.instr_count = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch against a program-level fetch model
module tb_instr_fetch;
  localparam logic [31:0] HLT = 32'hD440_0000;
  localparam logic [31:0] NOP = 32'hD503_201F;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  instr_fetch_if bus();
  instr_fetch dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [31:0] word;
    int unsigned wt;
    int unsigned rd;
    logic        br;
    logic        z;
    logic        bu;
    logic [63:0] off;
  } step_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
    logic [31:0] cnt;
  } exp_t;

  step_t       prog[$];
  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] mpc;
  logic [31:0] mcount;
  bit          mhalted;
  bit          tput_mode = 1'b0;
  int          cyc = 0;
  int          last_acc = -1;
  bit          prev_fetch_ack = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check64(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic fail_now(string name, string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic garbage();
    bus.branch        = 1'($urandom);
    bus.zero          = 1'($urandom);
    bus.branch_uncond = 1'($urandom);
    bus.branch_offset = {$urandom, $urandom};
  endtask

  function automatic step_t mk(logic [31:0] w, int unsigned wt, int unsigned rd,
                               logic br, logic z, logic bu, logic [63:0] off);
    step_t s;
    s.word = w; s.wt = wt; s.rd = rd; s.br = br; s.z = z; s.bu = bu; s.off = off;
    return s;
  endfunction

  task automatic nops(int n);
    for (int i = 0; i < n; i++) prog.push_back(mk(NOP, 0, 0, 1'b0, 1'b0, 1'b0, 64'h0));
  endtask

  // Monitor: every presented instruction must match the oldest issued fetch.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_fetch_ack = 1'b0;
    end else begin
      if (prev_fetch_ack) check64("ack_to_valid_latency", 64'(bus.instr_valid), 64'h1);
      prev_fetch_ack = bus.imem_req && bus.imem_ack;
      if (bus.imem_req && bus.imem_ack) begin
        if (exp_q.size() == 0) fail_now("fetch_unexpected", $sformatf("addr %h with no fetch issued", bus.imem_addr));
        else check64("fetch_addr", bus.imem_addr, exp_q[$].pc);
      end
      if (bus.instr_valid) begin
        check64("req_during_hold", 64'(bus.imem_req), 64'h0);
        if (exp_q.size() == 0) begin
          fail_now("valid_unexpected", $sformatf("instruction %h with nothing expected", bus.instruction));
        end else begin
          check64("instruction", 64'(bus.instruction), 64'(exp_q[0].word));
          check64("pc_out", bus.pc_out, exp_q[0].pc);
          if (bus.instr_ready) begin
            check64("instr_count", 64'(bus.instr_count), 64'(exp_q[0].cnt));
            if (tput_mode && last_acc >= 0) check64("throughput_gap", 64'(cyc - last_acc), 64'd2);
            last_acc = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic run_prog();
    step_t s;
    int    n;
    while (prog.size() > 0 && !mhalted) begin
      s = prog.pop_front();
      n = 0;
      while (bus.imem_req !== 1'b1 && n < 50) begin tick(); n++; end
      if (n == 50) begin
        fail_now("fetch_timeout", "imem_req never rose, required 1");
        prog.delete();
        return;
      end
      repeat (s.wt) begin bus.imem_ack = 1'b0; garbage(); tick(); end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = s.word;
      exp_q.push_back('{pc: mpc, word: s.word, cnt: mcount});
      tick();
      repeat (s.rd) begin
        bus.imem_ack   = 1'($urandom);
        bus.imem_rdata = $urandom;
        garbage();
        tick();
      end
      bus.imem_ack = 1'b0;
      n = 0;
      while (bus.instr_valid !== 1'b1 && n < 50) begin tick(); n++; end
      if (n == 50) begin
        fail_now("valid_timeout", "instr_valid never rose, required 1");
        prog.delete();
        return;
      end
      bus.instr_ready   = 1'b1;
      bus.branch        = s.br;
      bus.zero          = s.z;
      bus.branch_uncond = s.bu;
      bus.branch_offset = s.off;
      mcount = mcount + 32'd1;
      if (s.word == HLT) mhalted = 1'b1;
      else if (s.bu || (s.br && s.z)) mpc = mpc + s.off * 64'd4;
      else mpc = mpc + 64'd4;
      tick();
      bus.instr_ready = 1'b0;
      garbage();
    end
  endtask

  task automatic check_reset_outputs();
    check64("rst_imem_req", 64'(bus.imem_req), 64'h0);
    check64("rst_instr_valid", 64'(bus.instr_valid), 64'h0);
    check64("rst_instruction", 64'(bus.instruction), 64'h0);
    check64("rst_halted", 64'(bus.halted), 64'h0);
    check64("rst_instr_count", 64'(bus.instr_count), 64'h0);
    check64("rst_pc_out", bus.pc_out, 64'h0);
    check64("rst_imem_addr", bus.imem_addr, 64'h0);
  endtask

  // Entered at posedge+1; reset is asserted mid-cycle to exercise the asynchronous path.
  task automatic apply_reset(bit late_ack);
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs();
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = $urandom;
    bus.instr_ready = 1'b1;
    tick();
    check_reset_outputs();
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b0;
    exp_q.delete();
    prog.delete();
    mpc = 64'h0; mcount = 32'h0; mhalted = 1'b0; last_acc = -1;
    @(posedge clock);
    #1 reset_n = 1'b1;
    if (late_ack) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h1234_5678;
    end
    check64("idle_no_req", 64'(bus.imem_req), 64'h0);
    tick();
    bus.imem_ack = 1'b0;
    check64("first_req", 64'(bus.imem_req), 64'h1);
    check64("first_addr", bus.imem_addr, 64'h0);
    check64("first_valid", 64'(bus.instr_valid), 64'h0);
    check64("first_instruction", 64'(bus.instruction), 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [15:0] r;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    bus.branch = 1'b0; bus.zero = 1'b0; bus.branch_uncond = 1'b0; bus.branch_offset = '0;
    tick();

    apply_reset(1'b0);
    tput_mode = 1'b1;
    nops(4);
    run_prog();
    tput_mode = 1'b0;
    check64("count_after_four", 64'(bus.instr_count), 64'd4);
    check64("addr_after_four", bus.imem_addr, 64'h10);

    apply_reset(1'b0);
    nops(4);
    prog.push_back(mk(32'hB400_0040, 0, 0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE));
    run_prog();
    check64("cbz_taken_addr", bus.imem_addr, 64'h08);
    nops(1);
    run_prog();

    apply_reset(1'b0);
    nops(4);
    prog.push_back(mk(32'hB400_0040, 0, 0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE));
    run_prog();
    check64("cbz_not_taken_addr", bus.imem_addr, 64'h14);

    apply_reset(1'b0);
    nops(8);
    prog.push_back(mk(32'h8B02_0020, 0, 5, 1'b0, 1'b0, 1'b0, 64'h0));
    run_prog();
    check64("stall_next_addr", bus.imem_addr, 64'h24);

    apply_reset(1'b0);
    nops(12);
    prog.push_back(mk(HLT, 0, 0, 1'b0, 1'b0, 1'b0, 64'h0));
    run_prog();
    for (int i = 0; i < 20; i++) begin
      check64("halt_req", 64'(bus.imem_req), 64'h0);
      check64("halt_flag", 64'(bus.halted), 64'h1);
      check64("halt_valid", 64'(bus.instr_valid), 64'h0);
      check64("halt_pc_out", bus.pc_out, 64'h30);
      check64("halt_count", 64'(bus.instr_count), 64'd13);
      bus.imem_ack = 1'($urandom);
      bus.instr_ready = 1'($urandom);
      garbage();
      tick();
    end
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;

    apply_reset(1'b0);
    prog.push_back(mk(NOP, 0, 0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF));
    run_prog();
    check64("jump_to_top", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    nops(1);
    run_prog();
    check64("wrap_plus4", bus.imem_addr, 64'h0);
    prog.push_back(mk(NOP, 0, 0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF));
    prog.push_back(mk(NOP, 0, 0, 1'b1, 1'b0, 1'b1, 64'h1));
    run_prog();
    check64("wrap_branch", bus.imem_addr, 64'h0);

    apply_reset(1'b0);
    nops(2);
    run_prog();
    tick();
    check64("mid_fetch_req", 64'(bus.imem_req), 64'h1);
    apply_reset(1'b1);
    nops(2);
    run_prog();
    check64("after_reset_addr", bus.imem_addr, 64'h08);

    apply_reset(1'b0);
    for (int i = 0; i < 200; i++) begin
      w = $urandom;
      if (w == HLT) w = NOP;
      r = 16'($urandom);
      prog.push_back(mk(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                        ($urandom_range(0, 3) == 0), {{48{r[15]}}, r}));
    end
    prog.push_back(mk(HLT, 1, 2, 1'b1, 1'b1, 1'b1, 64'h5));
    run_prog();
    tick();
    check64("random_halted", 64'(bus.halted), 64'h1);
    check64("random_final_pc", bus.pc_out, mpc);
    check64("random_final_count", 64'(bus.instr_count), 64'(mcount));
    check64("random_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
